// File: rtl/i2c_target_regs.sv
`timescale 1ns/1ps
// I2C target with register pointer and auto-increment, oversampled on clk.
// Define I2C_TARGET_FILTER_EN to add a FILTER_LEN-cycle glitch filter on SCL/SDA.
module i2c_target_regs #(
    parameter logic [6:0] I2C_ADDRESS = 7'h48,
    parameter int         REGS        = 16,
    parameter int         FILTER_LEN  = 4,
    localparam int        AW          = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          busy
);

    if (REGS < 2 || REGS > 256 || (REGS & (REGS - 1)) != 0 || FILTER_LEN < 1) begin : g_cfg_err
        $error("i2c_target_regs: unsupported REGS/FILTER_LEN");
    end

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    scl_s, sda_s;
    logic [1:0]    raw, flt;
    logic          scl_f, sda_f, scl_q, sda_q;
    logic          scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg, rx_byte;
    logic          rw;
    logic [AW-1:0] ptr;
    logic          byte_done, addr_hit;

    assign raw = {scl_s[1], sda_s[1]};

`ifdef I2C_TARGET_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [1:0][CW-1:0] flt_cnt;

    // Output follows the raw line only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            flt     <= 2'b11;
            flt_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == flt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == CW'(FILTER_LEN - 1)) begin
                    flt[i]     <= raw[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign flt = raw;
`endif

    assign scl_f     = flt[1];
    assign sda_f     = flt[0];
    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    // Requiring SCL high on both samples keeps START/STOP apart from SCL edges.
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign rx_byte   = {shreg[6:0], sda_f};
    assign byte_done = scl_rise && (bit_cnt == 4'd7);
    assign addr_hit  = (rx_byte[7:1] == I2C_ADDRESS) && (rx_byte[7:1] != 7'd0);
    assign rd_addr   = ptr;

    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = ADDR;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR:      if (byte_done) state_nxt = addr_hit ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK:  if (scl_fall && sda_oe) state_nxt = rw ? RDATA : PTR;
                PTR:       if (byte_done) state_nxt = PTR_ACK;
                PTR_ACK:   if (scl_fall && sda_oe) state_nxt = WDATA;
                WDATA:     if (byte_done) state_nxt = WDATA_ACK;
                WDATA_ACK: if (scl_fall && sda_oe) state_nxt = WDATA;
                RDATA:     if (scl_fall && bit_cnt == 4'd8) state_nxt = RACK;
                RACK:      if (scl_rise) state_nxt = sda_f ? WAIT_STOP : RDATA;
                default:   state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state     <= IDLE;
            scl_s     <= 2'b11;
            sda_s     <= 2'b11;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            bit_cnt   <= '0;
            shreg     <= '0;
            rw        <= 1'b0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            scl_s     <= {scl_s[0], scl_in};
            sda_s     <= {sda_s[0], sda_in};
            scl_q     <= scl_f;
            sda_q     <= sda_f;
            wr_strobe <= 1'b0;
            if (wr_strobe) ptr <= ptr + 1'b1;

            if (start_det) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (byte_done) begin
                            if (state == ADDR) begin
                                rw <= rx_byte[0];
                                if (addr_hit) busy <= 1'b1;
                            end
                            if (state == PTR) ptr <= rx_byte[AW-1:0];
                            if (state == WDATA) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= ptr;
                                wr_data   <= rx_byte;
                            end
                        end
                    end
                    // First fall starts the ACK, second fall ends it; sda_oe tells them apart.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else if (state == ADDR_ACK && rw) begin
                                sda_oe <= ~rd_data[7];
                                shreg  <= {rd_data[6:0], 1'b0};
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                            end else if (bit_cnt == 4'd0) begin
                                sda_oe <= ~rd_data[7];
                                shreg  <= {rd_data[6:0], 1'b0};
                            end else begin
                                sda_oe <= ~shreg[7];
                                shreg  <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise && !sda_f) begin
                            ptr     <= ptr + 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
// Bus-master bench for i2c_target_regs: expected writes and bus replies go into
// scoreboard queues, a negedge monitor pops and compares them.
module tb_i2c_target_regs;

    localparam int REGS = 16;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          scl = 1'b1;
    logic          sda_m = 1'b1;
    logic          sda_bus;
    logic          sda_oe, wr_strobe, busy;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [7:0]    wr_data, rd_data;

    int n_vec = 0;
    int n_bad = 0;

    logic [AW+7:0] exp_wr[$];
    logic [8:0]    exp_rx[$];
    logic [AW+7:0] e_wr;
    logic [8:0]    e_rx;
    logic          rx_vld = 1'b0;
    logic [8:0]    rx_val = '0;
    string         rx_name = "";

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;
    assign rd_data = 8'(rd_addr);

    i2c_target_regs #(.I2C_ADDRESS(7'h48), .REGS(REGS), .FILTER_LEN(4)) dut (
        .clk(clk), .nreset(nreset), .scl_in(scl), .sda_in(sda_bus),
        .sda_oe(sda_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT-presented write strobe and bus reply against the scoreboard.
    always @(negedge clk) begin
        if (nreset && wr_strobe) begin
            if (exp_wr.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL wr_strobe: unexpected addr %0h data %0h expected none", wr_addr, wr_data);
            end else begin
                e_wr = exp_wr.pop_front();
                chk("wr_strobe addr/data", {20'h0, wr_addr, wr_data}, {20'h0, e_wr});
            end
        end
        if (rx_vld) begin
            if (exp_rx.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL %s: got %0h expected nothing", rx_name, rx_val);
            end else begin
                e_rx = exp_rx.pop_front();
                chk(rx_name, {23'h0, rx_val}, {23'h0, e_rx});
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL period of 20 clk; optional 2-clk low glitch in the high phase.
    task automatic bit_x(input logic b, input bit glitch, output logic r);
        clk_n(5); sda_m = b;
        clk_n(5); scl = 1'b1;
        if (glitch) begin
            clk_n(2); scl = 1'b0; clk_n(2); scl = 1'b1; clk_n(1);
        end else begin
            clk_n(5);
        end
        r = sda_bus;
        clk_n(5); scl = 1'b0;
    endtask

    task automatic start_c();
        clk_n(5); sda_m = 1'b1;
        clk_n(5); scl = 1'b1;
        clk_n(5); sda_m = 1'b0;
        clk_n(5); scl = 1'b0;
    endtask

    task automatic stop_c();
        clk_n(5); sda_m = 1'b0;
        clk_n(5); scl = 1'b1;
        clk_n(5); sda_m = 1'b1;
        clk_n(10);
    endtask

    task automatic present(input logic [8:0] v, input string name);
        rx_val = v; rx_name = name; rx_vld = 1'b1;
        clk_n(1);
        rx_vld = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string name,
                           input bit glitch = 1'b0);
        logic r;
        exp_rx.push_back({8'h0, exp_ack});
        for (int i = 7; i >= 0; i--) bit_x(b[i], glitch && (i == 7), r);
        bit_x(1'b1, 1'b0, r);
        present({8'h0, r}, name);
    endtask

    task automatic rd_byte(input logic [7:0] exp, input logic mack, input string name);
        logic [7:0] d;
        logic r;
        exp_rx.push_back({1'b0, exp});
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, 1'b0, r);
            d[i] = r;
        end
        present({1'b0, d}, name);
        bit_x(mack, 1'b0, r);
    endtask

    initial begin
        logic r;
        nreset = 1'b0;
        clk_n(4);
        chk("reset sda_oe", sda_oe, 0);
        chk("reset busy", busy, 0);
        chk("reset wr_strobe", wr_strobe, 0);
        chk("reset wr_addr", wr_addr, 0);
        chk("reset wr_data", wr_data, 0);
        chk("reset rd_addr", rd_addr, 0);
        nreset = 1'b1;
        clk_n(5);

        // Pointer write then two data writes with auto-increment
        exp_wr.push_back({4'h3, 8'hA5});
        exp_wr.push_back({4'h4, 8'h5A});
        start_c();
        wr_byte(8'h90, 1'b0, "t1 addr ack");
        chk("t1 busy set", busy, 1);
        wr_byte(8'h03, 1'b0, "t1 ptr ack");
        wr_byte(8'hA5, 1'b0, "t1 data0 ack");
        wr_byte(8'h5A, 1'b0, "t1 data1 ack");
        stop_c();
        chk("t1 busy after stop", busy, 0);

        // Read with repeated START, pointer wraps 15 -> 0
        start_c();
        wr_byte(8'h90, 1'b0, "t2 addr ack");
        wr_byte(8'h0E, 1'b0, "t2 ptr ack");
        start_c();
        wr_byte(8'h91, 1'b0, "t2 raddr ack");
        rd_byte(8'h0E, 1'b0, "t2 read0");
        rd_byte(8'h0F, 1'b0, "t2 read1");
        rd_byte(8'h00, 1'b1, "t2 read2 wrap");
        clk_n(6);
        chk("t2 sda released after nack", sda_oe, 0);
        chk("t2 busy before stop", busy, 1);
        stop_c();
        chk("t2 busy after stop", busy, 0);

        // Wrong address: no ACK, no strobe, never busy
        start_c();
        wr_byte(8'h92, 1'b1, "t3 addr nack");
        chk("t3 busy", busy, 0);
        wr_byte(8'h01, 1'b1, "t3 data nack");
        stop_c();
        chk("t3 busy after stop", busy, 0);

        // START mid-byte aborts the partial write
        exp_wr.push_back({4'h2, 8'h77});
        start_c();
        wr_byte(8'h90, 1'b0, "t4 addr ack");
        wr_byte(8'h01, 1'b0, "t4 ptr ack");
        bit_x(1'b1, 1'b0, r);
        bit_x(1'b0, 1'b0, r);
        bit_x(1'b1, 1'b0, r);
        bit_x(1'b0, 1'b0, r);
        start_c();
        wr_byte(8'h90, 1'b0, "t4 addr2 ack");
        wr_byte(8'h02, 1'b0, "t4 ptr2 ack");
        wr_byte(8'h77, 1'b0, "t4 data ack");
        stop_c();

        // Reset while the target drives a 0 bit (pointer 3 -> MSB 0)
        start_c();
        wr_byte(8'h91, 1'b0, "t5 raddr ack");
        clk_n(6);
        chk("t5 driving low bit", sda_oe, 1);
        nreset = 1'b0;
        clk_n(1);
        chk("t5 reset sda_oe", sda_oe, 0);
        chk("t5 reset busy", busy, 0);
        chk("t5 reset wr_strobe", wr_strobe, 0);
        chk("t5 reset wr_addr", wr_addr, 0);
        chk("t5 reset wr_data", wr_data, 0);
        chk("t5 reset rd_addr", rd_addr, 0);
        nreset = 1'b1;
        stop_c();
        exp_wr.push_back({4'h5, 8'h3C});
        start_c();
        wr_byte(8'h90, 1'b0, "t5 addr ack");
        wr_byte(8'h05, 1'b0, "t5 ptr ack");
        wr_byte(8'h3C, 1'b0, "t5 data ack");
        stop_c();
        start_c();
        wr_byte(8'h90, 1'b0, "t5 addr2 ack");
        wr_byte(8'h07, 1'b0, "t5 ptr2 ack");
        start_c();
        wr_byte(8'h91, 1'b0, "t5 raddr2 ack");
        rd_byte(8'h07, 1'b1, "t5 read");
        stop_c();

        // 2-clk SCL glitch during the first address bit
`ifdef I2C_TARGET_FILTER_EN
        exp_wr.push_back({4'h6, 8'h11});
        start_c();
        wr_byte(8'h90, 1'b0, "t6 glitch filtered addr ack", 1'b1);
        wr_byte(8'h06, 1'b0, "t6 ptr ack");
        wr_byte(8'h11, 1'b0, "t6 data ack");
        stop_c();
`else
        start_c();
        wr_byte(8'h90, 1'b1, "t6 glitch corrupts addr nack", 1'b1);
        stop_c();
        chk("t6 busy", busy, 0);
`endif

        clk_n(10);
        chk("write scoreboard drained", exp_wr.size(), 0);
        chk("reply scoreboard drained", exp_rx.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
